// File: rtl/usb_capture.sv
// Host-bound USB capture engine: decimates 8-bit channel samples, packs four per
// little-endian 32-bit word, buffers them in a show-ahead FIFO and streams them to the USB write port.
module usb_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [15:0]          decim,
    input  logic [7:0]           sample_in,
    input  logic                 sample_valid,
    output logic [31:0]          usb_wr_data,
    output logic                 usb_wr_valid,
    input  logic                 usb_wr_full,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          overflow_count,
    output logic [LEN_WIDTH-1:0] words_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] sample_cnt;
    logic [15:0]          decim_q;
    logic [15:0]          dec_cnt;
    logic [23:0]          pack;
    logic [1:0]           byte_idx;

    logic [31:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 space;

    logic                 accept;
    logic                 word_done;
    logic                 last_sample;
    logic                 flush_push;
    logic                 push;
    logic                 drop;
    logic [31:0]          push_word;

    // FIFO flags and the USB write handshake
    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop          = !fifo_empty && !usb_wr_full;
    // A pop in the same cycle frees a slot for a push into a full FIFO
    assign space        = !fifo_full || pop;
    assign usb_wr_valid = pop;
    assign usb_wr_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop || last_sample) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (byte_idx == 2'd0 || space) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        word_done   = 1'b0;
        last_sample = 1'b0;
        flush_push  = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;
        push_word   = {sample_in, pack};
        if (state == RUN && sample_valid && dec_cnt == '0) begin
            accept      = 1'b1;
            word_done   = (byte_idx == 2'd3);
            last_sample = (len_q != '0) && ((sample_cnt + LEN_WIDTH'(1)) == len_q);
        end
        // Partial word flush waits for space instead of dropping
        if (state == FLUSH && byte_idx != 2'd0 && space) begin
            flush_push = 1'b1;
            push_word  = {8'h00, pack};
        end
        push = (word_done && space) || flush_push;
        drop = word_done && !space;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            len_q          <= '0;
            decim_q        <= '0;
            sample_cnt     <= '0;
            dec_cnt        <= '0;
            pack           <= '0;
            byte_idx       <= '0;
            overflow_count <= '0;
            words_sent     <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == DRAIN) && (state_next == IDLE);
            if (state == IDLE && start) begin
                len_q          <= length;
                decim_q        <= decim;
                sample_cnt     <= '0;
                dec_cnt        <= '0;
                pack           <= '0;
                byte_idx       <= '0;
                overflow_count <= '0;
                words_sent     <= '0;
            end else begin
                if (pop) begin
                    words_sent <= words_sent + LEN_WIDTH'(1);
                end
                if (state == RUN && sample_valid) begin
                    dec_cnt <= (dec_cnt == decim_q) ? 16'd0 : dec_cnt + 16'd1;
                end
                if (accept) begin
                    sample_cnt <= sample_cnt + LEN_WIDTH'(1);
                    if (byte_idx == 2'd3) begin
                        byte_idx <= 2'd0;
                        pack     <= '0;
                    end else begin
                        pack[{byte_idx, 3'b000} +: 8] <= sample_in;
                        byte_idx                      <= byte_idx + 2'd1;
                    end
                end
                if (drop && overflow_count != 16'hFFFF) begin
                    overflow_count <= overflow_count + 16'd1;
                end
                if (flush_push) begin
                    byte_idx <= 2'd0;
                    pack     <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_capture.sv
// Scoreboard bench for usb_capture: stimulus queues expected USB words, a monitor
// pops and compares on every write strobe; status outputs are checked directly.
module tb_usb_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [31:0] length;
    logic [15:0] decim;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic [31:0] usb_wr_data;
    logic        usb_wr_valid;
    logic        usb_wr_full;
    logic        busy;
    logic        done;
    logic [15:0] overflow_count;
    logic [31:0] words_sent;

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;
    logic [31:0] exp_q[$];

    usb_capture #(.FIFO_DEPTH(16), .LEN_WIDTH(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .length        (length),
        .decim         (decim),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .usb_wr_data   (usb_wr_data),
        .usb_wr_valid  (usb_wr_valid),
        .usb_wr_full   (usb_wr_full),
        .busy          (busy),
        .done          (done),
        .overflow_count(overflow_count),
        .words_sent    (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && usb_wr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got 0x%08h expected no write", usb_wr_data);
                end else begin
                    check("usb_wr_data", usb_wr_data, exp_q.pop_front());
                end
            end
            if (reset_n === 1'b1 && done === 1'b1) begin
                done_cnt++;
                check("done_after_writes", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cap(input logic [31:0] len, input logic [15:0] dec, input logic with_stop);
        start  = 1'b1;
        stop   = with_stop;
        length = len;
        decim  = dec;
        tick();
        start  = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic send(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            sample_in    = first + 8'(i);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: busy still 1 expected 0", name);
        end
        tick();
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; length = '0; decim = '0;
        sample_in = '0; sample_valid = 1'b0; usb_wr_full = 1'b0;
        repeat (3) tick();
        check("rst_data", usb_wr_data, 32'h0);
        check("rst_valid", 32'(usb_wr_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ovf", 32'(overflow_count), 32'h0);
        check("rst_words", words_sent, 32'h0);
        reset_n = 1'b1;
        tick();

        // Two full words, length-terminated
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        done_cnt = 0;
        start_cap(32'd8, 16'd0, 1'b0);
        check("t1_busy_after_start", 32'(busy), 32'h1);
        send(8'h01, 8);
        wait_idle("t1");
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_words_sent", words_sent, 32'd2);
        check("t1_busy", 32'(busy), 32'h0);

        // Partial final word is zero-padded
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h00000605);
        start_cap(32'd6, 16'd0, 1'b0);
        send(8'h01, 6);
        wait_idle("t2");
        check("t2_ovf", 32'(overflow_count), 32'd0);
        check("t2_words_sent", words_sent, 32'd2);

        // Decimation by 3
        exp_q.push_back(32'h09060300);
        start_cap(32'd4, 16'd2, 1'b0);
        send(8'h00, 12);
        wait_idle("t3");
        check("t3_words_sent", words_sent, 32'd1);

        // Continuous capture into a blocked sink: 20 words, 16 held, 4 dropped
        usb_wr_full = 1'b1;
        done_cnt = 0;
        start_cap(32'd0, 16'd0, 1'b0);
        send(8'h00, 80);
        pulse_stop();
        repeat (3) tick();
        check("t4_ovf", 32'(overflow_count), 32'd4);
        check("t4_busy_blocked", 32'(busy), 32'h1);
        check("t4_no_write_full", 32'(usb_wr_valid), 32'h0);
        for (int w = 0; w < 16; w++) begin
            exp_q.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        end
        usb_wr_full = 1'b0;
        wait_idle("t4");
        check("t4_done_cnt", 32'(done_cnt), 32'd1);
        check("t4_words_sent", words_sent, 32'd16);

        // Stop with one pending byte; simultaneous start+stop in IDLE keeps start
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h00000005);
        start_cap(32'd0, 16'd0, 1'b1);
        check("t5_start_wins", 32'(busy), 32'h1);
        check("t5_ovf_cleared", 32'(overflow_count), 32'd0);
        send(8'h01, 5);
        pulse_stop();
        send(8'h40, 6);
        wait_idle("t5");
        send(8'h50, 4);
        check("t5_words_sent", words_sent, 32'd2);
        check("t5_idle", 32'(busy), 32'h0);

        // Asynchronous reset mid-capture with two words buffered
        usb_wr_full = 1'b1;
        start_cap(32'd0, 16'd0, 1'b0);
        send(8'h10, 8);
        send(8'h20, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_data", usb_wr_data, 32'h0);
        check("t6_rst_valid", 32'(usb_wr_valid), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_ovf", 32'(overflow_count), 32'h0);
        check("t6_rst_words", words_sent, 32'h0);
        usb_wr_full = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        exp_q.push_back(32'hA4A3A2A1);
        start_cap(32'd4, 16'd0, 1'b0);
        send(8'hA1, 4);
        wait_idle("t6");
        check("t6_words_sent", words_sent, 32'd1);
        check("t6_ovf", 32'(overflow_count), 32'd0);

        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_capture.md
Name: usb_capture

Overview:
- Capture engine for the host-bound direction of the USB sample path. It takes 8-bit channel samples (ADC input, DDS, audio or any muxed source), applies decimation, and packs four samples into each 32-bit word.
- Packed words are buffered in a small FIFO and written to the USB write interface, which has a write strobe and a full backpressure signal.
- It is the counterpart of the DAC channel's USB read FIFO path and sits between the channel sample mux and the USB bridge write port.

Parameters:
- FIFO_DEPTH, 16: packed-word FIFO depth; power of 2, minimum 4.
- LEN_WIDTH, 32: width of the length and words_sent counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a capture when idle.
- stop  input  1  single-cycle pulse; ends a capture early.
- length  input  LEN_WIDTH  samples to capture after decimation; 0 means continuous until stop.
- decim  input  16  decimation factor: accept one of every decim+1 valid samples.
- sample_in  input  8  sample data.
- sample_valid  input  1  sample_in qualifier.
- usb_wr_data  output  32  packed word at the FIFO head.
- usb_wr_valid  output  1  write strobe; the sink captures usb_wr_data on this cycle.
- usb_wr_full  input  1  sink full; no write may occur while it is high.
- busy  output  1  high from an accepted start until the FIFO has drained.
- done  output  1  one-cycle pulse on the transition to IDLE.
- overflow_count  output  16  packed words dropped because the FIFO was full; saturates at 0xFFFF.
- words_sent  output  LEN_WIDTH  words written to USB in the current capture.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE; FIFO is empty; packer, decimation and sample counters are cleared.
  - All outputs are 0: usb_wr_data=0, usb_wr_valid=0, busy=0, done=0, overflow_count=0, words_sent=0.
  - Reset asserted mid-capture aborts immediately; any partial word is lost.
- States: IDLE, RUN, FLUSH, DRAIN.
- IDLE:
  - start=1 latches length and decim.
  - It clears words_sent, overflow_count, the packer and the decimation counter, then goes to RUN.
  - busy rises the cycle after start.
- RUN, per sample_valid cycle:
  - The decimation counter gates acceptance: a sample is accepted when the counter equals 0.
  - The counter increments, and wraps to 0 after it reaches decim.
  - The first valid sample after start is always accepted.
- Packing: accepted sample k of a word (k=0..3) goes to bits [8k+7:8k], so the word is little-endian.
  - On the 4th byte, the word is pushed into the FIFO in the same cycle.
  - If the FIFO is full at that push, the word is dropped, overflow_count increments and the sample count still advances.
- Length termination: when the accepted-sample count reaches a nonzero length, go to FLUSH. The final sample is included.
- stop in RUN goes to FLUSH. stop in any other state is ignored. start when not IDLE is ignored.
- start and stop in the same cycle while IDLE: start wins, and the stop is ignored.
- FLUSH:
  - If 1 to 3 bytes are pending, the word is zero-padded in the upper bytes and pushed when the FIFO has space. This push waits; it never drops.
  - Then go to DRAIN.
  - If no bytes are pending, go to DRAIN in the next cycle.
  - Samples are ignored in FLUSH and DRAIN.
- DRAIN: when the FIFO is empty, go to IDLE, pulse done for 1 cycle and drop busy.
- USB write handshake:
  - usb_wr_valid = FIFO not empty AND usb_wr_full=0. This is combinational from the FIFO flags and the registered full input.
  - The FIFO pops in the same cycle. usb_wr_data is the FIFO head (show-ahead) and is stable while usb_wr_valid=0.
  - Writes are allowed in every state except IDLE-after-reset. Words left from the previous capture cannot exist, because DRAIN empties the FIFO.
  - Sustained throughput is 1 word per cycle.
- Simultaneous push and pop on a full FIFO: the push is accepted, because the pop frees the slot in the same cycle. No overflow is counted.
- words_sent increments on each usb_wr_valid cycle and wraps at 2^LEN_WIDTH.
- Latency: the 4th accepted byte reaches usb_wr_valid on the cycle after its push, given an empty FIFO and full=0.

Test Plan:
- length=8, decim=0, samples 0x01..0x08 on consecutive cycles, full=0 -> writes 0x04030201 then 0x08070605; done pulses once; words_sent=2; busy=0.
- length=6, samples 0x01..0x06 -> writes 0x04030201 then 0x00000605 (zero-padded); overflow_count=0.
- decim=2, length=4, samples 0x00..0x0B continuous -> accepts 0x00, 0x03, 0x06, 0x09 -> single write 0x09060300.
- length=0, FIFO_DEPTH=16, usb_wr_full=1, 80 samples, then stop, then full released -> overflow_count=4; 16 writes starting 0x03020100; done after the 16th write.
- length=0, samples 0x01..0x05, stop -> writes 0x04030201 then 0x00000005; further samples ignored; IDLE after drain.
- reset_n pulsed low mid-RUN with 2 words buffered -> all outputs 0 immediately (asynchronous); no writes after release; next start behaves as a fresh capture.
